// File: rtl/regfile_bypass.sv
// Banked register file with two registered read ports, two writeback ports,
// same-cycle write-to-read bypass and a per-entry busy scoreboard driving stall.
module regfile_bypass #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NBANK   = 2,
   parameter int ZERO_R0 = 1,
   parameter int BANK_W  = (NBANK > 1) ? $clog2(NBANK) : 1
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [BANK_W-1:0] ra_bank,
   input  logic [BANK_W-1:0] rb_bank,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic              rvalid,
   input  logic              wa_en,
   input  logic [BANK_W-1:0] wa_bank,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic [DATA_W-1:0] wa_data,
   input  logic              wa_tag,
   input  logic              wb_en,
   input  logic [BANK_W-1:0] wb_bank,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              busy_set_en,
   input  logic [BANK_W-1:0] busy_bank,
   input  logic [ADDR_W-1:0] busy_addr,
   output logic              stall
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem  [NBANK][DEPTH];
   logic [DEPTH-1:0]  busy [NBANK];
   logic              last_tag;

   logic              wa_acc_p0, wa_wr_p0, wb_wr_p0, bs_ok_p0, rd_fire_p0;
   logic              ra_busy_p0, rb_busy_p0;
   logic [DATA_W-1:0] ra_val_p0, rb_val_p0;

   // Entry exists and is writable/readable (bank in range, not the hardwired zero).
   function automatic logic tgt_ok(input logic [BANK_W-1:0] bank,
                                   input logic [ADDR_W-1:0] addr);
      tgt_ok = (32'(bank) < NBANK) && !(ZERO_R0 != 0 && bank == '0 && addr == '0);
   endfunction

   assign wa_acc_p0  = wa_en && (wa_tag != last_tag);
   assign wa_wr_p0   = wa_acc_p0 && tgt_ok(wa_bank, wa_addr);
   assign wb_wr_p0   = wb_en && tgt_ok(wb_bank, wb_addr);
   assign bs_ok_p0   = busy_set_en && tgt_ok(busy_bank, busy_addr);
   assign stall      = rd_en && (ra_busy_p0 || rb_busy_p0);
   assign rd_fire_p0 = rd_en && !stall;

   always_comb begin
      ra_val_p0  = '0;
      ra_busy_p0 = 1'b0;
      if (tgt_ok(ra_bank, ra_addr)) begin
         if (wb_wr_p0 && wb_bank == ra_bank && wb_addr == ra_addr)
            ra_val_p0 = wb_data;
         else if (wa_wr_p0 && wa_bank == ra_bank && wa_addr == ra_addr)
            ra_val_p0 = wa_data;
         else begin
            ra_val_p0  = mem[ra_bank][ra_addr];
            ra_busy_p0 = busy[ra_bank][ra_addr];
         end
      end
   end

   always_comb begin
      rb_val_p0  = '0;
      rb_busy_p0 = 1'b0;
      if (tgt_ok(rb_bank, rb_addr)) begin
         if (wb_wr_p0 && wb_bank == rb_bank && wb_addr == rb_addr)
            rb_val_p0 = wb_data;
         else if (wa_wr_p0 && wa_bank == rb_bank && wa_addr == rb_addr)
            rb_val_p0 = wa_data;
         else begin
            rb_val_p0  = mem[rb_bank][rb_addr];
            rb_busy_p0 = busy[rb_bank][rb_addr];
         end
      end
   end

   // p0 -> p1: array update, scoreboard update, registered read data
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int b = 0; b < NBANK; b++) begin
            busy[b] <= '0;
            for (int a = 0; a < DEPTH; a++)
               mem[b][a] <= '0;
         end
         last_tag <= 1'b0;
         rdata_a  <= '0;
         rdata_b  <= '0;
         rvalid   <= 1'b0;
      end else begin
         if (wa_acc_p0)
            last_tag <= wa_tag;
         if (wa_wr_p0) begin
            mem[wa_bank][wa_addr]  <= wa_data;
            busy[wa_bank][wa_addr] <= 1'b0;
         end
         // Port B lands after port A so it wins on a shared target.
         if (wb_wr_p0) begin
            mem[wb_bank][wb_addr]  <= wb_data;
            busy[wb_bank][wb_addr] <= 1'b0;
         end
         if (bs_ok_p0)
            busy[busy_bank][busy_addr] <= 1'b1;
         rvalid <= rd_fire_p0;
         if (rd_fire_p0) begin
            rdata_a <= ra_val_p0;
            rdata_b <= rb_val_p0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: tag filter, bypass priority, zero register,
// scoreboard stall and reset-priority scenarios with hand-computed expectations.
module tb_regfile_bypass;

   logic        CLK = 1'b0;
   logic        reset;
   logic        rd_en;
   logic [0:0]  ra_bank, rb_bank;
   logic [4:0]  ra_addr, rb_addr;
   logic [31:0] rdata_a, rdata_b;
   logic        rvalid;
   logic        wa_en;
   logic [0:0]  wa_bank;
   logic [4:0]  wa_addr;
   logic [31:0] wa_data;
   logic        wa_tag;
   logic        wb_en;
   logic [0:0]  wb_bank;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        busy_set_en;
   logic [0:0]  busy_bank;
   logic [4:0]  busy_addr;
   logic        stall;

   int n_cmp = 0;
   int n_bad = 0;

   regfile_bypass dut (
      .CLK(CLK), .reset(reset), .rd_en(rd_en),
      .ra_bank(ra_bank), .rb_bank(rb_bank), .ra_addr(ra_addr), .rb_addr(rb_addr),
      .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid(rvalid),
      .wa_en(wa_en), .wa_bank(wa_bank), .wa_addr(wa_addr), .wa_data(wa_data), .wa_tag(wa_tag),
      .wb_en(wb_en), .wb_bank(wb_bank), .wb_addr(wb_addr), .wb_data(wb_data),
      .busy_set_en(busy_set_en), .busy_bank(busy_bank), .busy_addr(busy_addr),
      .stall(stall)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      rd_en = 0; wa_en = 0; wb_en = 0; busy_set_en = 0;
   endtask

   task automatic rd(input logic [0:0] ba, input logic [4:0] aa,
                     input logic [0:0] bb, input logic [4:0] ab);
      rd_en = 1; ra_bank = ba; ra_addr = aa; rb_bank = bb; rb_addr = ab;
   endtask

   task automatic wa(input logic tg, input logic [0:0] b, input logic [4:0] a, input logic [31:0] d);
      wa_en = 1; wa_tag = tg; wa_bank = b; wa_addr = a; wa_data = d;
   endtask

   task automatic wb(input logic [0:0] b, input logic [4:0] a, input logic [31:0] d);
      wb_en = 1; wb_bank = b; wb_addr = a; wb_data = d;
   endtask

   task automatic bset(input logic [0:0] b, input logic [4:0] a);
      busy_set_en = 1; busy_bank = b; busy_addr = a;
   endtask

   initial begin
      reset = 1; idle();
      ra_bank = 0; rb_bank = 0; ra_addr = 0; rb_addr = 0;
      wa_bank = 0; wa_addr = 0; wa_data = 0; wa_tag = 0;
      wb_bank = 0; wb_addr = 0; wb_data = 0; busy_bank = 0; busy_addr = 0;
      step(); step();
      reset = 0;
      check("rst_rdata_a", rdata_a, 32'h0);
      check("rst_rdata_b", rdata_b, 32'h0);
      check("rst_rvalid", {31'b0, rvalid}, 32'h0);

      // tag filter: first write after reset needs tag=1
      wa(0, 0, 4, 32'h1234); step();
      wa(1, 0, 3, 32'hAAAA); step();
      wa(1, 0, 3, 32'hBBBB); step();
      idle(); rd(0, 3, 0, 4); #1;
      check("tag_stall", {31'b0, stall}, 32'h0);
      step();
      check("tag_dup_dropped", rdata_a, 32'hAAAA);
      check("tag0_first_dropped", rdata_b, 32'h0);
      check("tag_rvalid", {31'b0, rvalid}, 32'h1);

      // toggled tag accepted, with same-cycle port A bypass
      wa(0, 0, 3, 32'hCCCC); rd(0, 3, 0, 3); step();
      check("bypass_a", rdata_a, 32'hCCCC);
      check("bypass_a_portb", rdata_b, 32'hCCCC);

      idle(); step();
      check("hold_rvalid", {31'b0, rvalid}, 32'h0);
      check("hold_rdata_a", rdata_a, 32'hCCCC);

      // A and B hit the same entry: B wins, bypassed to both ports
      wa(1, 1, 5, 32'h11); wb(1, 5, 32'h22); rd(1, 5, 1, 5); step();
      check("prio_rdata_a", rdata_a, 32'h22);
      check("prio_rdata_b", rdata_b, 32'h22);
      check("prio_rvalid", {31'b0, rvalid}, 32'h1);
      idle(); rd(1, 5, 0, 3); step();
      check("prio_stored", rdata_a, 32'h22);
      check("prio_other", rdata_b, 32'hCCCC);

      // hardwired zero entry
      idle(); wb(0, 0, 32'hFFFF); bset(0, 0); step();
      idle(); rd(0, 0, 0, 0); #1;
      check("zero_stall", {31'b0, stall}, 32'h0);
      step();
      check("zero_rdata_a", rdata_a, 32'h0);
      check("zero_rdata_b", rdata_b, 32'h0);

      // scoreboard stall and clear-by-write
      idle(); bset(0, 7); step();
      idle(); rd(0, 7, 0, 3); #1;
      check("sb_stall", {31'b0, stall}, 32'h1);
      step();
      check("sb_rvalid", {31'b0, rvalid}, 32'h0);
      check("sb_hold", rdata_a, 32'h0);
      wb(0, 7, 32'h5); #1;
      check("sb_clear_stall", {31'b0, stall}, 32'h0);
      step();
      check("sb_rdata", rdata_a, 32'h5);
      check("sb_rvalid2", {31'b0, rvalid}, 32'h1);

      // port B busy; same-cycle set and clear leaves entry busy
      idle(); bset(1, 2); step();
      idle(); rd(0, 3, 1, 2); #1;
      check("sbb_stall", {31'b0, stall}, 32'h1);
      wb(1, 2, 32'h66); bset(1, 2); #1;
      check("sbb_clear_stall", {31'b0, stall}, 32'h0);
      step();
      check("sbb_rdata_b", rdata_b, 32'h66);
      idle(); rd(0, 3, 1, 2); #1;
      check("set_wins_stall", {31'b0, stall}, 32'h1);
      idle(); wb(1, 2, 32'h67); step();

      // reset beats a busy entry, live rvalid and same-cycle writes
      idle(); bset(0, 9); step();
      idle(); rd(0, 3, 0, 3); step();
      check("pre_rst_rvalid", {31'b0, rvalid}, 32'h1);
      reset = 1; wb(0, 9, 32'h77); bset(0, 10); rd(0, 3, 0, 3); step();
      reset = 0; idle();
      check("mid_rst_rvalid", {31'b0, rvalid}, 32'h0);
      check("mid_rst_rdata_a", rdata_a, 32'h0);
      check("mid_rst_rdata_b", rdata_b, 32'h0);
      wa(0, 0, 3, 32'h99); step();
      idle(); rd(0, 9, 0, 10); #1;
      check("mid_rst_stall", {31'b0, stall}, 32'h0);
      step();
      check("mid_rst_entry", rdata_a, 32'h0);
      check("mid_rst_set_ignored", rdata_b, 32'h0);
      idle(); rd(0, 3, 1, 5); step();
      check("post_rst_tag0_dropped", rdata_a, 32'h0);
      check("post_rst_bank1", rdata_b, 32'h0);

      idle(); step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; each bank holds 2^ADDR_W entries.
REQ-003 SHALL have parameter NBANK, default 2, bank count (bank 0 integer, bank 1 float); BANK_W = max(1, clog2(NBANK)).
REQ-004 SHALL have parameter ZERO_R0, default 1; when 1, bank 0 entry 0 is hardwired zero.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 CLK  in  1  clock; all state changes on posedge.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 rd_en  in  1  read request for ports A and B.
REQ-009 ra_bank, rb_bank  in  BANK_W  read bank select, ports A/B.
REQ-010 ra_addr, rb_addr  in  ADDR_W  read address, ports A/B.
REQ-011 rdata_a, rdata_b  out  DATA_W  registered read data.
REQ-012 rvalid  out  1  rdata_a/rdata_b updated by the previous edge.
REQ-013 wa_en, wa_bank, wa_addr, wa_data, wa_tag  in  1/BANK_W/ADDR_W/DATA_W/1  writeback port A (pipeline), with a toggle tag for duplicate suppression.
REQ-014 wb_en, wb_bank, wb_addr, wb_data  in  1/BANK_W/ADDR_W/DATA_W  writeback port B (load/UART).
REQ-015 busy_set_en, busy_bank, busy_addr  in  1/BANK_W/ADDR_W  marks the destination of an issued instruction as pending.
REQ-016 stall  out  1  combinational; the read cannot be served this cycle.

Function
REQ-017 Port A write SHALL be accepted only when wa_en=1 and wa_tag != last_tag; on acceptance last_tag <= wa_tag.
REQ-018 Port B write SHALL be accepted whenever wb_en=1, regardless of the tag.
REQ-019 Same-cycle accepted A and B writes to the same bank/addr SHALL store wb_data (B wins).
REQ-020 Writes with bank >= NBANK SHALL be discarded; reads with bank >= NBANK SHALL return 0 and are never busy.
REQ-021 With ZERO_R0=1: writes to bank 0 addr 0 SHALL be discarded, reads SHALL return 0, and busy is never set for that entry.
REQ-022 On an edge with rd_en=1 and stall=0, rdata_x SHALL capture the entry at (rx_bank, rx_addr); read latency is 1 cycle.
REQ-023 Bypass: if an accepted write in the same cycle targets a read address, the captured value SHALL be the new write data (B over A), not the old array value.
REQ-024 rvalid SHALL be 1 exactly in the cycle after an edge with rd_en=1 and stall=0; otherwise rvalid=0 and rdata_a/rdata_b SHALL hold.
REQ-025 busy_set_en SHALL set busy[busy_bank][busy_addr] at the edge.
REQ-026 An accepted write SHALL clear busy for its target; a same-cycle set and clear of one entry SHALL leave it set.
REQ-027 stall SHALL be rd_en AND (busy[ra] OR busy[rb]); an entry cleared by an accepted write this cycle SHALL NOT count as busy.
REQ-028 Ports A and B reading the same entry SHALL return identical data.

Reset
REQ-029 On reset: all entries 0, all busy bits 0, last_tag 0, rdata_a = rdata_b = 0, rvalid 0.
REQ-030 Reset SHALL take priority over every same-cycle write, read and busy_set.
REQ-031 After reset is deasserted, the first port A write SHALL require wa_tag=1.

Verification
REQ-032 Tag filter: wa_en=1, wa_tag=1, bank0 addr3 = 0xAAAA; next cycle the same write with wa_tag=1 and data 0xBBBB; read addr3 -> 0xAAAA.
REQ-033 Bypass/priority: in one cycle A writes bank1 addr5 = 0x11, B writes bank1 addr5 = 0x22, and port A reads bank1 addr5 -> rdata_a = 0x22 next cycle, rvalid=1.
REQ-034 Zero reg: B writes bank0 addr0 = 0xFFFF and busy_set is applied to bank0 addr0 -> read returns 0, stall=0.
REQ-035 Scoreboard: busy_set bank0 addr7, then read addr7 -> stall=1 and rvalid=0 next cycle; a B write of 0x5 to addr7 plus a same-cycle read -> stall=0, rdata = 0x5.
REQ-036 Reset mid-operation: reset asserted with a busy entry, rvalid=1 and a same-cycle write -> next cycle rvalid=0, rdata=0, the entry reads 0, stall=0.
